// File: rtl/r2sdf_pkg.sv
// Shared types and fixed-point helpers for the R2SDF FFT stage and its twiddle table.
package r2sdf_pkg;

  localparam int unsigned AccW = 64;

  typedef logic signed [AccW-1:0] acc_t;

  // Full-precision complex value; stage data of any width W <= AccW is narrowed from this.
  typedef struct packed {
    acc_t re;
    acc_t im;
  } cplx_acc_t;

  // Largest positive Q1.(tw-1) value, used as the twiddle unit magnitude.
  function automatic int tw_scale(input int unsigned tw);
    return (1 << (tw - 1)) - 1;
  endfunction

  function automatic acc_t sat(input acc_t x, input int unsigned w);
    acc_t hi;
    acc_t lo;
    hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo = -(acc_t'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Round half-up at bit sh-1, then arithmetic shift right by sh.
  function automatic acc_t round_shift(input acc_t x, input int unsigned sh);
    if (sh == 0) return x;
    return (x + (acc_t'(1) <<< (sh - 1))) >>> sh;
  endfunction

endpackage

// File: rtl/r2sdf_twiddle_rom.sv
// Combinational twiddle table W_2D^k = cos(pi*k/D) - j*sin(pi*k/D) in Q1.(TW-1),
// generated at elaboration with round-to-nearest.
module r2sdf_twiddle_rom
  import r2sdf_pkg::*;
#(
  parameter int unsigned D  = 4,
  parameter int unsigned KW = 2,
  parameter int unsigned TW = 16
) (
  input  logic [KW-1:0]        k,
  output logic signed [TW-1:0] w_re,
  output logic signed [TW-1:0] w_im
);

  localparam int unsigned Depth = 1 << KW;
  localparam real Pi = 3.14159265358979323846;

  function automatic int round_real(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  logic signed [TW-1:0] rom_re [Depth];
  logic signed [TW-1:0] rom_im [Depth];

  for (genvar i = 0; i < Depth; i++) begin : g_entry
    if (i == 0) begin : g_unit
      assign rom_re[i] = TW'(tw_scale(TW));
      assign rom_im[i] = '0;
    end else begin : g_rot
      localparam real Ang  = Pi * real'(i) / real'(D);
      localparam int  CosV = round_real($cos(Ang) * real'(tw_scale(TW)));
      localparam int  SinV = round_real($sin(Ang) * real'(tw_scale(TW)));
      assign rom_re[i] = TW'(CosV);
      assign rom_im[i] = TW'(-SinV);
    end
  end

  assign w_re = rom_re[k];
  assign w_im = rom_im[k];

endmodule

// File: rtl/r2sdf_stage_fx.sv
// Fixed-point radix-2 SDF decimation-in-frequency butterfly stage with twiddle multiply.
// Define R2SDF_SCALE_EN for a 1/2 gain per stage; otherwise sums/differences saturate.
module r2sdf_stage_fx
  import r2sdf_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned S  = 1,
  parameter int unsigned W  = 16,
  parameter int unsigned TW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic                out_valid,
  output logic                out_sof,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im
);

  localparam int unsigned D  = 1 << (N - S);
  localparam int unsigned PW = N - S + 1;
  localparam int unsigned KW = (N > S) ? N - S : 1;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  // Narrow a W+1-bit butterfly result back to W bits.
  function automatic logic signed [W-1:0] reduce(input logic signed [W:0] x);
`ifdef R2SDF_SCALE_EN
    return x[W:1];
`else
    return W'(sat(acc_t'(x), W));
`endif
  endfunction

  logic [PW-1:0]        pos_q, pos_d, pos_eff;
  logic                 primed_q, primed_d, primed_eff;
  logic                 half, fire;
  logic [KW-1:0]        k;
  cplx_t                dl_q [D];
  cplx_t                dl_new;
  logic signed [W-1:0]  dl_re, dl_im;
  logic signed [W-1:0]  sum_re, sum_im, diff_re, diff_im;
  logic signed [W-1:0]  rot_re, rot_im, res_re, res_im;
  logic signed [TW-1:0] tw_re, tw_im;
  logic signed [W+TW:0] a_re, a_im, b_re, b_im, p_re, p_im;
  cplx_acc_t            prod;

  assign dl_re = dl_q[D-1].re;
  assign dl_im = dl_q[D-1].im;

  // A start-of-frame marker forces position 0; arriving mid-frame it also restarts priming.
  always_comb begin
    pos_eff    = in_sof ? '0 : pos_q;
    primed_eff = (in_sof && (pos_q != '0)) ? 1'b0 : primed_q;
    half       = pos_eff[PW-1];
    k          = KW'(pos_eff & PW'(D - 1));
    fire       = in_valid && (half || primed_eff);
    pos_d      = in_valid ? pos_eff + PW'(1) : pos_q;
    primed_d   = in_valid ? (primed_eff || (pos_eff == PW'(D - 1))) : primed_q;
  end

  r2sdf_twiddle_rom #(
    .D (D),
    .KW(KW),
    .TW(TW)
  ) u_rom (
    .k   (k),
    .w_re(tw_re),
    .w_im(tw_im)
  );

  always_comb begin
    sum_re  = reduce({dl_re[W-1], dl_re} + {in_re[W-1], in_re});
    sum_im  = reduce({dl_im[W-1], dl_im} + {in_im[W-1], in_im});
    diff_re = reduce({dl_re[W-1], dl_re} - {in_re[W-1], in_re});
    diff_im = reduce({dl_im[W-1], dl_im} - {in_im[W-1], in_im});

    a_re    = {{(TW+1){dl_re[W-1]}}, dl_re};
    a_im    = {{(TW+1){dl_im[W-1]}}, dl_im};
    b_re    = {{(W+1){tw_re[TW-1]}}, tw_re};
    b_im    = {{(W+1){tw_im[TW-1]}}, tw_im};
    p_re    = a_re * b_re - a_im * b_im;
    p_im    = a_re * b_im + a_im * b_re;
    prod.re = acc_t'(p_re);
    prod.im = acc_t'(p_im);
    rot_re  = W'(sat(round_shift(prod.re, TW - 1), W));
    rot_im  = W'(sat(round_shift(prod.im, TW - 1), W));

    if (half) begin
      res_re = sum_re;
      res_im = sum_im;
    end else if (k == '0) begin
      // Unit twiddle: exact pass-through, no rounding through the multiplier.
      res_re = dl_re;
      res_im = dl_im;
    end else begin
      res_re = rot_re;
      res_im = rot_im;
    end

    dl_new.re = half ? diff_re : in_re;
    dl_new.im = half ? diff_im : in_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q     <= '0;
      primed_q  <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      pos_q     <= pos_d;
      primed_q  <= primed_d;
      out_valid <= fire;
      out_sof   <= fire && half && (k == '0);
      if (fire) begin
        out_re <= res_re;
        out_im <= res_im;
      end
    end
  end

  // Delay-line contents need no reset; priming masks them until rewritten.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      dl_q[0] <= dl_new;
      for (int i = 1; i < D; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_r2sdf_stage_fx.sv
// Self-checking bench for r2sdf_stage_fx (N=3, S=1, W=16, TW=16, D=4) with a frame-level model.
module tb_r2sdf_stage_fx;

  typedef struct {
    bit v;
    bit sof;
    int re;
    int im;
  } exp_t;

`ifdef R2SDF_SCALE_EN
  localparam int ConstSum = 1000;
  localparam int ImpVal   = 500;
  localparam int TwRe     = 354;
  localparam int TwIm     = -354;
  localparam int BigSum   = 32000;
`else
  localparam int ConstSum = 2000;
  localparam int ImpVal   = 1000;
  localparam int TwRe     = 707;
  localparam int TwIm     = -707;
  localparam int BigSum   = 32767;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_sof = 1'b0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;
  logic               out_valid, out_sof;
  logic signed [15:0] out_re, out_im;

  int checks = 0;
  int errors = 0;

  exp_t sbq[$];
  exp_t mon_e;
  int   got_re[$];
  int   got_im[$];
  bit   got_sof[$];

  int mpos = 0;
  bit mprimed = 1'b0;
  int xr[8], xi[8], dr[4], di[4];
  int last_re = 0, last_im = 0;
  int rnd_re[8], rnd_im[8];

  always #5 clk = ~clk;

  r2sdf_stage_fx #(
    .N (3),
    .S (1),
    .W (16),
    .TW(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .out_re   (out_re),
    .out_im   (out_im)
  );

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic int red(input int x);
`ifdef R2SDF_SCALE_EN
    return x >>> 1;
`else
    return clamp16(longint'(x));
`endif
  endfunction

  function automatic longint rndr(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    return -longint'($rtoi(0.5 - x));
  endfunction

  function automatic void twm(input int ar, input int ai, input int k,
                              output int o_re, output int o_im);
    real    a;
    longint wr, wi, pr, pm;
    if (k == 0) begin
      o_re = ar;
      o_im = ai;
      return;
    end
    a    = 3.14159265358979323846 * k / 4.0;
    wr   = rndr($cos(a) * 32767.0);
    wi   = -rndr($sin(a) * 32767.0);
    pr   = ar * wr - ai * wi;
    pm   = ar * wi + ai * wr;
    o_re = clamp16((pr + 16384) >>> 15);
    o_im = clamp16((pm + 16384) >>> 15);
  endfunction

  // One input cycle: drive at the falling edge and queue the expected registered result.
  task automatic step(input bit v, input bit sof, input int re, input int im);
    exp_t e;
    int   p, k, o_re, o_im;
    @(negedge clk);
    in_valid = v;
    in_sof   = sof;
    in_re    = 16'(re);
    in_im    = 16'(im);
    e.v      = 1'b0;
    e.sof    = 1'b0;
    if (v) begin
      if (sof && mpos != 0) mprimed = 1'b0;
      if (sof) mpos = 0;
      p     = mpos;
      xr[p] = re;
      xi[p] = im;
      if (p >= 4) begin
        k       = p - 4;
        e.v     = 1'b1;
        e.sof   = (p == 4);
        last_re = red(xr[k] + re);
        last_im = red(xi[k] + im);
        dr[k]   = red(xr[k] - re);
        di[k]   = red(xi[k] - im);
      end else if (mprimed) begin
        twm(dr[p], di[p], p, o_re, o_im);
        e.v     = 1'b1;
        last_re = o_re;
        last_im = o_im;
      end
      if (p == 3) mprimed = 1'b1;
      mpos = (p + 1) % 8;
    end
    e.re = last_re;
    e.im = last_im;
    sbq.push_back(e);
  endtask

  task automatic idle_drain();
    step(1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #2;
  endtask

  task automatic const_frame(input int re, input bit gap);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, re, 0);
      if (gap) step(1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic rand_frame(input bit gap);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, rnd_re[i], rnd_im[i]);
      if (gap) step(1'b0, 1'b0, 0, 0);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("out_valid", out_valid, mon_e.v);
      chk("out_sof", out_sof, mon_e.sof);
      chk("out_re", out_re, mon_e.re);
      chk("out_im", out_im, mon_e.im);
      if (out_valid === 1'b1) begin
        got_re.push_back(out_re);
        got_im.push_back(out_im);
        got_sof.push_back(out_sof);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      rnd_re[i] = int'($urandom_range(40000, 0)) - 20000;
      rnd_im[i] = int'($urandom_range(40000, 0)) - 20000;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous frames: constant, impulse at x0, impulse at x1, large constant, random, zeros.
    const_frame(1000, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, (i == 0) ? 1000 : 0, 0);
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, (i == 1) ? 1000 : 0, 0);
    const_frame(32000, 1'b0);
    rand_frame(1'b0);
    const_frame(0, 1'b0);
    idle_drain();

    chk("n_out_continuous", got_re.size(), 44);
    if (got_re.size() >= 44) begin
      chk("const_sum_re", got_re[0], ConstSum);
      chk("const_sum_sof", got_sof[0], 1);
      chk("const_sum_last", got_re[3], ConstSum);
      chk("const_diff_re", got_re[4], 0);
      chk("const_diff_sof", got_sof[4], 0);
      chk("imp_sum_re", got_re[8], ImpVal);
      chk("imp_sum_im", got_im[8], 0);
      chk("imp_diff_re", got_re[12], ImpVal);
      chk("x1_sum_re", got_re[17], ImpVal);
      chk("x1_diff_re", got_re[21], TwRe);
      chk("x1_diff_im", got_im[21], TwIm);
      chk("big_sum_re", got_re[24], BigSum);
    end

    // Same frames with in_valid toggling every other cycle.
    const_frame(32000, 1'b1);
    rand_frame(1'b1);
    const_frame(0, 1'b1);
    idle_drain();
    chk("n_out_toggled", got_re.size(), 68);

    // Resync: sof at pos=2 restarts priming; then two clean frames.
    step(1'b1, 1'b1, 500, 100);
    step(1'b1, 1'b0, -300, 50);
    rand_frame(1'b0);
    const_frame(1200, 1'b0);
    idle_drain();
    chk("n_out_resync", got_re.size(), 82);

    // Mid-frame reset clears outputs immediately, then a clean restart.
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, 700 + i, -i);
    idle_drain();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_sof", out_sof, 0);
    chk("midrst_out_re", out_re, 0);
    chk("midrst_out_im", out_im, 0);
    mpos    = 0;
    mprimed = 1'b0;
    last_re = 0;
    last_im = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rand_frame(1'b0);
    const_frame(-1500, 1'b0);
    idle_drain();
    chk("sb_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
